// File: rtl/rf_wb_scheduler_pkg.sv
// Shared constants, source-select encoding and helpers for the register-file
// writeback scheduler.
package rf_wb_scheduler_pkg;

    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_sel_e;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_W-1:0] idx);
        return NUM_REGS'(1'b1) << idx;
    endfunction

endpackage

// File: rtl/rf_wb_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter between the ALU and load writeback sources.
// A contested cycle goes to whichever source did not win the previous grant.
module rr_arbiter2
    import rf_wb_scheduler_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic alu_valid,
    input  logic mem_valid,
    output logic alu_grant,
    output logic mem_grant
);

    src_sel_e last_r;

    // Grant selection from the requests and the last winner
    always_comb begin
        alu_grant = alu_valid & (~mem_valid | (last_r == SRC_MEM));
        mem_grant = mem_valid & (~alu_valid | (last_r == SRC_ALU));
    end

    // Last-winner register; moves only when a grant is actually made
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_r <= SRC_MEM;
        end else if (alu_grant) begin
            last_r <= SRC_ALU;
        end else if (mem_grant) begin
            last_r <= SRC_MEM;
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Register-file write-port scheduler: busy scoreboard for RAW/WAW stalls,
// ALU/load writeback arbitration and a registered write stage.
module rf_wb_scheduler
    import rf_wb_scheduler_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    output logic                issue_ready,
    input  logic [ADDR_W-1:0]   issue_src1,
    input  logic [ADDR_W-1:0]   issue_src2,
    input  logic                issue_has_dest,
    input  logic [ADDR_W-1:0]   issue_dest,
    input  logic                alu_wb_valid,
    output logic                alu_wb_ready,
    input  logic [ADDR_W-1:0]   alu_wb_dest,
    input  logic [DATA_W-1:0]   alu_wb_data,
    input  logic                mem_wb_valid,
    output logic                mem_wb_ready,
    input  logic [ADDR_W-1:0]   mem_wb_dest,
    input  logic [DATA_W-1:0]   mem_wb_data,
    output logic                rf_wr_en,
    output logic [ADDR_W-1:0]   rf_wr_dest,
    output logic [DATA_W-1:0]   rf_wr_data,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic                wb_err
);

    logic                alu_grant_s;
    logic                mem_grant_s;
    logic                any_grant_s;
    logic [ADDR_W-1:0]   win_dest_s;
    logic [DATA_W-1:0]   win_data_s;
    logic                issue_fire_s;
    logic [NUM_REGS-1:0] set_mask_s;
    logic [NUM_REGS-1:0] clr_mask_s;
    logic [NUM_REGS-1:0] busy_next_s;

    logic [NUM_REGS-1:0] busy_r;
    logic                rf_wr_en_r;
    logic [ADDR_W-1:0]   rf_wr_dest_r;
    logic [DATA_W-1:0]   rf_wr_data_r;
    logic                wb_err_r;

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_wb_valid),
        .mem_valid (mem_wb_valid),
        .alu_grant (alu_grant_s),
        .mem_grant (mem_grant_s)
    );

    // Hazard check uses only registered busy bits, so a clearing bit still stalls
    always_comb begin
        issue_ready  = ~(busy_r[issue_src1] | busy_r[issue_src2] |
                         (issue_has_dest & busy_r[issue_dest]));
        issue_fire_s = issue_valid & issue_ready;
    end

    // Winner mux and ready handshakes
    always_comb begin
        any_grant_s  = alu_grant_s | mem_grant_s;
        alu_wb_ready = alu_grant_s;
        mem_wb_ready = mem_grant_s;
        if (mem_grant_s) begin
            win_dest_s = mem_wb_dest;
            win_data_s = mem_wb_data;
        end else begin
            win_dest_s = alu_wb_dest;
            win_data_s = alu_wb_data;
        end
    end

    // Scoreboard update: set is applied after clear so a same-index set wins
    always_comb begin
        if (rf_wr_en_r) begin
            clr_mask_s = reg_onehot(rf_wr_dest_r);
        end else begin
            clr_mask_s = '0;
        end
        if (issue_fire_s & issue_has_dest) begin
            set_mask_s = reg_onehot(issue_dest);
        end else begin
            set_mask_s = '0;
        end
        busy_next_s = (busy_r & ~clr_mask_s) | set_mask_s;
    end

    // Scoreboard, write stage and sticky error state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r       <= '0;
            rf_wr_en_r   <= 1'b0;
            rf_wr_dest_r <= '0;
            rf_wr_data_r <= '0;
            wb_err_r     <= 1'b0;
        end else begin
            busy_r     <= busy_next_s;
            rf_wr_en_r <= any_grant_s;
            if (any_grant_s) begin
                rf_wr_dest_r <= win_dest_s;
                rf_wr_data_r <= win_data_s;
            end else begin
                rf_wr_dest_r <= rf_wr_dest_r;
                rf_wr_data_r <= rf_wr_data_r;
            end
            if (any_grant_s & ~busy_r[win_dest_s]) begin
                wb_err_r <= 1'b1;
            end else begin
                wb_err_r <= wb_err_r;
            end
        end
    end

    assign rf_wr_en   = rf_wr_en_r;
    assign rf_wr_dest = rf_wr_dest_r;
    assign rf_wr_data = rf_wr_data_r;
    assign busy_mask  = busy_r;
    assign wb_err     = wb_err_r;

endmodule

// File: doc/rf_wb_scheduler.md
Name: rf_wb_scheduler

Overview:
- Sequences the single write port of the 16x16 register file between two writeback sources: the ALU and the memory/load unit.
- Keeps a per-register busy scoreboard so the issue stage stalls on RAW and WAW hazards.
- Sits between the issue stage, the execution units and the register file write port.
- Drives a registered write enable; the register file writes only when rf_wr_en=1.

Parameters:
DATA_W, 16, register data width
ADDR_W, 4, register index width; NUM_REGS = 2**ADDR_W (16)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-high reset
issue_valid  in  1  issue stage presents an instruction
issue_ready  out  1  instruction may issue this cycle
issue_src1  in  ADDR_W  first source register
issue_src2  in  ADDR_W  second source register
issue_has_dest  in  1  instruction writes a register
issue_dest  in  ADDR_W  destination register
alu_wb_valid  in  1  ALU writeback request
alu_wb_ready  out  1  ALU writeback accepted this cycle
alu_wb_dest  in  ADDR_W  ALU destination
alu_wb_data  in  DATA_W  ALU result
mem_wb_valid  in  1  load writeback request
mem_wb_ready  out  1  load writeback accepted this cycle
mem_wb_dest  in  ADDR_W  load destination
mem_wb_data  in  DATA_W  load data
rf_wr_en  out  1  register file write enable
rf_wr_dest  out  ADDR_W  register file write index
rf_wr_data  out  DATA_W  register file write data
busy_mask  out  NUM_REGS  scoreboard, bit n = register n has a write pending
wb_err  out  1  sticky: writeback targeted a non-busy register

Behaviour:
- Reset (async, immediate): busy_mask=0, rf_wr_en=0, rf_wr_dest=0, rf_wr_data=0, wb_err=0, rr_last=MEM (ALU wins the first tie).
- Reset mid-operation: in-flight grants and pending busy bits are discarded. No write is issued after rst deasserts until a new grant.
- issue_ready (combinational from registered state):
  - It is !(busy[src1] | busy[src2] | (issue_has_dest & busy[dest])).
  - It is independent of issue_valid.
  - There is no bypass: a bit being cleared this cycle still stalls.
- Issue fires when issue_valid & issue_ready. If issue_has_dest, busy[issue_dest] sets at the next edge.
- Arbitration (combinational grant, one per cycle):
  - Only one valid: that source is granted.
  - Both valid: the source not granted last (rr_last) is granted.
  - rr_last updates only on a grant.
  - alu_wb_ready / mem_wb_ready = that source's grant. A source holds valid, dest and data stable until ready.
- Write stage (1-cycle latency):
  - On a grant, the next edge loads rf_wr_en=1 and rf_wr_dest / rf_wr_data from the winner.
  - With no grant, rf_wr_en=0 and dest/data hold their previous values.
- Busy clear:
  - When rf_wr_en=1, busy[rf_wr_dest] clears at the same edge on which the register file captures the data.
  - A source read from the next cycle therefore sees the new value.
- Simultaneous set and clear of the same index in one cycle: the set wins and the bit stays 1. This cannot occur legally because of the WAW stall, but the rule is defined.
- wb_err sets when a grant is made for a dest whose busy bit is 0. The write is still performed. wb_err clears only on rst.
- Back-to-back grants are legal every cycle. Throughput is one write per cycle.

Decomposition:
- Shared package: ADDR_W, DATA_W, NUM_REGS constants; source-select enum {SRC_ALU, SRC_MEM}.
- One natural sub-module: rr_arbiter2 (2-way round-robin, valid in / grant out, last-grant register).
- Scoreboard and write-stage registers stay in the top level.

Test Plan:
1. Reset, then issue dest=3 (srcs 1,2) -> busy_mask=0x0008 next cycle. A following issue with src1=3 gets issue_ready=0.
2. ALU wb dest=3, data=0xBEEF -> alu_wb_ready=1 the same cycle. Next cycle rf_wr_en=1, rf_wr_dest=3, rf_wr_data=0xBEEF. The cycle after, busy_mask=0 and issue_ready=1.
3. Busy r4 and r5; ALU (r4, 0x1111) and MEM (r5, 0x2222) valid together for two cycles:
   - First cycle: ALU granted.
   - Second cycle: MEM granted.
   - rf_wr sequence r4/0x1111, then r5/0x2222.
4. Issue dest=7 while busy[7]=1 -> issue_ready=0 (WAW). After r7 writeback completes, issue_ready=1.
5. MEM wb to non-busy r9 -> write performed; wb_err=1 and stays 1 until rst.
6. rst asserted with busy_mask=0x00F0 and a grant pending -> all outputs zero immediately, with no rf_wr_en pulse after deassertion.
